// File: rtl/jk_excite_counter.sv
// jk_excite_counter: up/down/load counter built from JK flip-flops, exporting J/K excitation.
// Define JK_DONTCARE_EN for minimal don't-care excitation (j = nx, k = ~nx); default is strict.
module jk_excite_counter #(
   parameter int W = 4
) (
   input  logic         c,
   input  logic         nrst,
   input  logic         en,
   input  logic         up,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] j,
   output logic [W-1:0] k,
   output logic         tc,
   output logic [7:0]   wraps
);
   logic [W-1:0] nx;
   always_comb begin
      nx = ld ? d : en ? (up ? q + W'(1) : q - W'(1)) : q;
   end
`ifdef JK_DONTCARE_EN
   assign j = nx;
   assign k = ~nx;
`else
   assign j = nx & ~q;
   assign k = ~nx & q;
`endif
   assign tc = ~ld & en & (up ? &q : ~|q);
   // State advances only through the JK characteristic equation.
   always_ff @(posedge c or negedge nrst) begin
      if (!nrst) begin
         q     <= '0;
         wraps <= '0;
      end else begin
         q <= (j & ~q) | (~k & q);
         if (tc && wraps != 8'hFF) wraps <= wraps + 8'd1;
      end
   end
endmodule

// File: tb/tb_jk_excite_counter.sv
// tb_jk_excite_counter: randomized and directed checks against an arithmetic model of the counter.
module tb_jk_excite_counter;
   localparam int W = 4;
   localparam int M = 1 << W;
   logic c = 0, nrst = 0, en = 0, up = 0, ld = 0;
   logic [W-1:0] d = '0;
   logic [W-1:0] q, j, k;
   logic tc;
   logic [7:0] wraps;
   int n_cmp = 0, n_bad = 0;
   int mq = 0, mw = 0;
   bit checking = 0;

   jk_excite_counter #(.W(W)) dut (.c(c), .nrst(nrst), .en(en), .up(up), .ld(ld), .d(d),
      .q(q), .j(j), .k(k), .tc(tc), .wraps(wraps));

   always #5 c = ~c;

   function automatic int model_nx();
      if (ld) return int'(d);
      if (!en) return mq;
      return up ? (mq + 1) % M : (mq + M - 1) % M;
   endfunction

   function automatic bit model_tc();
      return !ld && en && (up ? mq == M - 1 : mq == 0);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge c or negedge nrst) begin
      if (!nrst) begin
         mq <= 0;
         mw <= 0;
      end else begin
         mq <= model_nx();
         if (model_tc() && mw < 255) mw <= mw + 1;
      end
   end

   always @(negedge c) begin
      if (checking) begin
         int nx, ej, ek;
         nx = model_nx();
`ifdef JK_DONTCARE_EN
         ej = nx;
         ek = ~nx & (M - 1);
`else
         ej = nx & ~mq & (M - 1);
         ek = ~nx & mq & (M - 1);
`endif
         chk("q", int'(q), mq);
         chk("wraps", int'(wraps), mw);
         chk("tc", int'(tc), int'(model_tc()));
         chk("j", int'(j), ej);
         chk("k", int'(k), ek);
         chk("jk_next", int'((j & ~q) | (~k & q)), nx);
      end
   end

   task automatic setin(input bit l, input int dv, input bit e, input bit u);
      ld = l;
      d = W'(dv);
      en = e;
      up = u;
   endtask

   task automatic tick();
      @(posedge c);
      #1;
   endtask

   task automatic drive(input bit l, input int dv, input bit e, input bit u);
      setin(l, dv, e, u);
      tick();
   endtask

   initial begin
      int w0;
      repeat (2) @(posedge c);
      #1;
      chk("reset_q", int'(q), 0);
      chk("reset_wraps", int'(wraps), 0);
      nrst = 1;
      checking = 1;
      drive(0, 0, 1, 1);
      chk("first_count", int'(q), 1);
      // up wrap through all-ones
      drive(1, 'hE, 0, 0);
      drive(0, 0, 1, 1);
      chk("up_F", int'(q), 'hF);
      drive(0, 0, 1, 1);
      chk("up_0", int'(q), 0);
      drive(0, 0, 1, 1);
      chk("up_1", int'(q), 1);
      chk("up_wraps", int'(wraps), 1);
      // down wrap through zero
      drive(0, 0, 1, 0);
      chk("down_0", int'(q), 0);
      setin(0, 0, 1, 0);
      #1;
`ifndef JK_DONTCARE_EN
      chk("down_j", int'(j), 'hF);
      chk("down_k", int'(k), 0);
`endif
      chk("down_tc", int'(tc), 1);
      tick();
      chk("down_F", int'(q), 'hF);
      chk("down_wraps", int'(wraps), 2);
      // load beats count
      drive(1, 5, 0, 0);
      setin(1, 'hA, 1, 1);
      #1;
      chk("ld_j", int'(j), 'hA);
      chk("ld_k", int'(k), 5);
      chk("ld_tc", int'(tc), 0);
      tick();
      chk("ld_q", int'(q), 'hA);
      chk("ld_wraps", int'(wraps), 2);
      // hold
      drive(1, 6, 0, 0);
      setin(0, 'hF, 0, 1);
      #1;
`ifdef JK_DONTCARE_EN
      chk("hold_j", int'(j), 6);
      chk("hold_k", int'(k), 9);
`else
      chk("hold_j", int'(j), 0);
      chk("hold_k", int'(k), 0);
`endif
      repeat (5) tick();
      chk("hold_q", int'(q), 6);
      // saturation
      for (int i = 0; i < 260; i++) begin
         drive(1, 'hF, 0, 0);
         drive(0, 0, 1, 1);
      end
      chk("sat_wraps", int'(wraps), 255);
      // async reset mid-count, checked before the next edge
      drive(1, 9, 0, 0);
      #2;
      nrst = 0;
      #1;
      chk("async_q", int'(q), 0);
      chk("async_wraps", int'(wraps), 0);
      setin(0, 0, 1, 1);
      #1;
      nrst = 1;
      tick();
      chk("post_reset_q", int'(q), 1);
      // randomized traffic with occasional mid-cycle resets
      for (int i = 0; i < 3000; i++) begin
         w0 = $urandom_range(0, 99);
         setin(w0 < 8, $urandom_range(0, M - 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
         if (w0 == 99) begin
            #2;
            nrst = 0;
            #5;
            nrst = 1;
            @(posedge c);
            #1;
         end else begin
            tick();
         end
      end
      checking = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jk_excite_counter.md
# jk_excite_counter

Parameterised up/down counter with load, built as a bank of edge-triggered JK flip-flops whose J/K inputs are derived from the desired next state. It is the excitation (inverse) side of the JK/T/D latch conversions already in the lab library: instead of computing next state from J/K, it computes J/K from current and next state. The J/K vectors are exported so benches can compare them against hand-derived excitation tables.

## Interface
- W, default 4: counter width in bits (W >= 2).
- c  input  1  clock; all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- ld  input  1  synchronous load request.
- d  input  W  load value.
- q  output  W  current counter state (JK flip-flop outputs).
- j  output  W  J excitation for each bit (combinational).
- k  output  W  K excitation for each bit (combinational).
- tc  output  1  terminal count (combinational).
- wraps  output  8  registered count of wrap-around events.

## Operation
- Target next state nx, priority order:
  - ld = 1: nx = d (en, up ignored).
  - else en = 1: nx = q + 1 (up = 1) or q - 1 (up = 0), modulo 2^W.
  - else: nx = q.
- Excitation per bit i derived from (q[i], nx[i]); see Configuration for exact form.
- Each bit is a JK flip-flop: on rising c, q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i]). The register must be written in this JK form, not as q <= nx; equivalence q_next == nx is a required property.
- tc = ~ld & en & (up ? q == all-ones : q == 0).
- wraps: on rising c, if tc = 1, wraps <= wraps + 1 (8-bit, saturates at 255, no wrap). ld never increments wraps even when d causes a numeric jump across zero.
- Reset (nrst low, any time, independent of c): q = 0, wraps = 0 immediately. j, k, tc follow combinationally from the reset state and current inputs.

## Timing
- Latency: ld/count effect visible on q one rising edge after the request is sampled.
- j, k, tc: zero-cycle combinational from q, en, up, ld, d.
- wraps updates on the same edge as the wrapping q transition.
- Reset deassertion: first state change on the first rising c with nrst high; no extra cycle required.
- Simultaneous ld and en: load wins, no count, no wrap increment.
- up changing every cycle is legal; each edge uses the up value sampled at that edge.
- W-bit boundaries: all-ones + 1 -> 0 and 0 - 1 -> all-ones, tc high in the cycle before the edge.

## Configuration
- JK_DONTCARE_EN defined: minimal excitation using don't-cares. j[i] = nx[i], k[i] = ~nx[i]. A bit that holds 0 therefore shows j=0,k=1; a holding 1 shows j=1,k=0.
- JK_DONTCARE_EN undefined (default): strict excitation, inactive input forced low. j[i] = nx[i] & ~q[i], k[i] = ~nx[i] & q[i]. Holding bits show j=k=0; j=k=1 never occurs.
- q, tc, wraps are identical in both builds; only j/k differ.

## Test plan
- Reset: drive nrst low mid-count with q=4'h9, wraps=3 -> q=0, wraps=0 asynchronously, before the next edge; after release, en=1, up=1 gives q=1 after one edge.
- Up wrap (W=4): ld d=4'hE, then en=1, up=1 for 3 edges -> q = F, 0, 1; tc high only while q=F; wraps=1.
- Down wrap: from q=1, en=1, up=0 for 2 edges -> q = 0, F; wraps increments once; strict build at q=0->F shows j=4'hF, k=0.
- Load priority: q=5, ld=1, d=4'hA, en=1, up=1 -> q=A after one edge; strict j=4'hA, k=4'h5 during request; wraps unchanged; tc=0.
- Hold: en=0, ld=0, q=6 for 5 edges -> q stays 6; strict j=k=0; JK_DONTCARE_EN build j=4'h6, k=4'h9.
- Saturation: force 260 up-wraps (ld F then count, repeated) -> wraps stops at 255; every cycle checks JK-form q_next equals nx in both builds.
